keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the oven's 4x3 matrix keypad, synchronises and debounces the column returns, and produces the 10-bit one-hot digit vector consumed by the time-entry/control stage (`keypad[9:0]`). It sits directly upstream of time entry and is the only block touching the physical keypad pins. It outputs a steady vector while a digit is held, plus a one-cycle strobe per new press.

## Interface
- `SCAN_DIV`, 4096: clock cycles each row is driven; legal minimum 4.
- `DEBOUNCE_CNT`, 4: consecutive identical full-matrix frames required before the stable key changes; legal minimum 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `row_n`  out  4  row drive, active low, exactly one bit low at all times.
- `col_n`  in  3  column returns, active low (external pull-ups), asynchronous to `clk`.
- `keypad`  out  10  one-hot debounced digit, `keypad[k]` = digit k held; all-zero = no valid key.
- `key_strobe`  out  1  one-cycle pulse when `keypad` changes to a new non-zero value.

## Operation
- Key map: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#; columns 0..2 left to right.
- `col_n` passes through a 2-FF synchroniser before any use.
- Scan: row counter 0..3 and dwell counter 0..SCAN_DIV-1; the row advances when dwell = SCAN_DIV-1, wrapping 3→0.
- Sampling: on dwell = SCAN_DIV-1, the inverted synchronised columns are stored into a 12-bit frame accumulator at bits [3*row+2 : 3*row].
- Frame end (row 3 sample): accumulator reduces to a candidate code:
  - exactly one bit set and that bit is a digit → that digit;
  - zero bits, `*`, `#`, or two or more bits set → NONE.
- Debounce: if candidate = previous candidate, the stable counter increments and saturates at DEBOUNCE_CNT; otherwise the counter resets to 1 and the previous candidate is updated. When the counter reaches DEBOUNCE_CNT, the stable code takes the candidate.
- `keypad` is a registered one-hot decode of the stable code.
- `key_strobe` is asserted for one cycle in the cycle `keypad` is updated, but only if the new stable code is a digit and differs from the old one. Digit→different digit also strobes. Digit→NONE does not strobe.
- Held key: no repeat strobes.

## Timing
- Reset (resetn = 0 at an edge):
  - `row_n` = 4'b1110;
  - dwell and row counters = 0;
  - accumulator and synchroniser = 0;
  - candidate and stable = NONE;
  - stable counter = 0;
  - `keypad` = 0; `key_strobe` = 0.
- Reset mid-scan or mid-debounce discards all partial state; scanning restarts at row 0 on the first edge after release.
- Frame period = 4*SCAN_DIV cycles.
- A column change must be stable ≥2 cycles before the row's sample point to be seen.
- Press-to-`keypad` latency: between DEBOUNCE_CNT and DEBOUNCE_CNT+1 frames, plus 1 cycle for the output register.
- `key_strobe` coincides with the first cycle of the new `keypad` value.
- Simultaneous multi-key presses produce NONE, which releases any stable digit after DEBOUNCE_CNT frames.

## Structure
- Shared header `keypad_defs.vh`:
  - NROWS = 4, NCOLS = 3;
  - 4-bit key code encoding: 0–9 digits, 4'hF = NONE;
  - the position-to-code map.
- Sub-module `keypad_debounce`: candidate/stable registers, saturating counter, strobe generation. Parameter DEBOUNCE_CNT. Input is the code plus a frame-valid pulse; outputs are the stable code and strobe.
- Scanner, synchroniser, frame reduction and one-hot decode remain in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3 (frame = 16 cycles), with a bench matrix model.
- Reset, then 40 cycles with no keys → `row_n` cycles 1110,1101,1011,0111 every 4 cycles; `keypad` = 0; no strobe.
- Hold digit 5 (row1, col1) indefinitely → `keypad` = 10'b0000100000 within 3–4 frames + 1 cycle; exactly one strobe; no repeats.
- Digit 7 bouncing every 10 cycles for 3 frames, then solid → no output during bounce; `keypad[7]` follows 3 solid frames; one strobe.
- Hold 2 and 8 together → `keypad` stays 0 with no strobe. With 3 held (stable) then 9 added → `keypad` clears to 0 after 3 frames.
- Press `*` or `#` → `keypad` = 0, no strobe. Press 0 → `keypad[0]` = 1 with strobe.
- Digit 4 stable, then resetn low 1 cycle mid-row-2 → next edge `keypad` = 0, `row_n` = 1110. With 4 still held, `keypad[4]` reasserts after 3 frames with a new strobe.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad geometry, key-code encoding and the position-to-code map
// used by the scanner and its debounce stage.
package keypad_scanner_pkg;

  localparam int NROWS   = 4;
  localparam int NCOLS   = 3;
  localparam int NKEYS   = NROWS * NCOLS;
  localparam int NDIGITS = 10;

  typedef logic [3:0]       key_code_t;
  typedef logic [NKEYS-1:0] frame_t;

  localparam key_code_t KEY_NONE = 4'hF;

  // Frame bit 3*row+col to key code; '*' and '#' carry no digit and map to NONE.
  function automatic key_code_t key_code_at(input logic [3:0] pos);
    key_code_t code;
    case (pos)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd5;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd7;
      4'd7:    code = 4'd8;
      4'd8:    code = 4'd9;
      4'd10:   code = 4'd0;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input key_code_t code);
    return code < 4'd10;
  endfunction

  function automatic logic [NDIGITS-1:0] digit_onehot(input key_code_t code);
    logic [NDIGITS-1:0] vec;
    for (int i = 0; i < NDIGITS; i++) begin
      vec[i] = (code == 4'(i));
    end
    return vec;
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Frame-rate debounce: a key code must repeat for DEBOUNCE_CNT frames
// before it becomes the stable code; new digits raise a one-cycle strobe.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      frame_valid,
  input  key_code_t frame_code,
  output key_code_t stable_code,
  output logic      stable_strobe
);

  localparam int             CW      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CNT);

  key_code_t     cand_code;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_next;
  logic          take;

  always_comb begin
    cnt_next = stable_cnt;
    if (frame_code != cand_code) begin
      cnt_next = CW'(1);
    end else if (stable_cnt != CNT_MAX) begin
      cnt_next = stable_cnt + CW'(1);
    end
    take = frame_valid && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cand_code     <= KEY_NONE;
      stable_cnt    <= '0;
      stable_code   <= KEY_NONE;
      stable_strobe <= 1'b0;
    end else begin
      stable_strobe <= 1'b0;
      if (frame_valid) begin
        cand_code  <= frame_code;
        stable_cnt <= cnt_next;
      end
      // Re-taking the same code while saturated is harmless: no strobe.
      if (take) begin
        stable_code   <= frame_code;
        stable_strobe <= is_digit(frame_code) && (frame_code != stable_code);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column synchroniser, frame capture
// and reduction, debounce, and registered one-hot digit output.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [NROWS-1:0]   row_n,
  input  logic [NCOLS-1:0]   col_n,
  output logic [NDIGITS-1:0] keypad,
  output logic               key_strobe
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0]    dwell;
  logic [1:0]       row;
  logic [1:0]       row_next;
  logic [NCOLS-1:0] col_s1;
  logic [NCOLS-1:0] col_s2;
  frame_t           acc;
  frame_t           frame;
  logic             sample;
  logic             frame_end;
  logic [3:0]       hits;
  logic [3:0]       hit_pos;
  key_code_t        frame_code;
  key_code_t        stable_code;
  logic             stable_strobe;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Dwell runs down from SCAN_DIV-1; terminal count is the row's sample point.
  assign sample    = (dwell == '0);
  assign frame_end = sample && (row == 2'(NROWS - 1));
  assign row_next  = row + 2'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dwell <= DW'(SCAN_DIV - 1);
      row   <= '0;
      row_n <= 4'b1110;
      acc   <= '0;
    end else if (sample) begin
      dwell                    <= DW'(SCAN_DIV - 1);
      row                      <= row_next;
      row_n                    <= ~(NROWS'(1) << row_next);
      acc[NCOLS*row +: NCOLS]  <= ~col_s2;
    end else begin
      dwell <= dwell - DW'(1);
    end
  end

  // Complete frame as it stands on this cycle, including the row being sampled.
  always_comb begin
    frame                       = acc;
    frame[NCOLS*row +: NCOLS]   = ~col_s2;
  end

  always_comb begin
    hits    = '0;
    hit_pos = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (frame[i]) begin
        hits    = hits + 4'd1;
        hit_pos = 4'(i);
      end
    end
    frame_code = (hits == 4'd1) ? key_code_at(hit_pos) : KEY_NONE;
  end

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk           (clk),
    .resetn        (resetn),
    .frame_valid   (frame_end),
    .frame_code    (frame_code),
    .stable_code   (stable_code),
    .stable_strobe (stable_strobe)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      keypad     <= '0;
      key_strobe <= 1'b0;
    end else begin
      keypad     <= digit_onehot(stable_code);
      key_strobe <= stable_strobe;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural key matrix driving the column returns from the row drive.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [9:0]  keypad;
  logic        key_strobe;
  logic [11:0] pressed;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int s0;
  logic [3:0] exp_row;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .row_n      (row_n),
    .col_n      (col_n),
    .keypad     (keypad),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        for (int c = 0; c < 3; c++) begin
          if (pressed[3*r+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (key_strobe) strobes++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge just before the first post-reset edge.
  task automatic do_reset();
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn  = 1'b0;
    pressed = '0;

    // Idle scan: row walks every 4 cycles, nothing reported.
    do_reset();
    s0 = strobes;
    check("rst_row", 32'(row_n), 32'h1110 & 32'hF | 32'(4'b1110));
    check("rst_keypad", 32'(keypad), 32'h0);
    check("rst_strobe", 32'(key_strobe), 32'h0);
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      exp_row = 4'b0001 << ((k / 4) % 4);
      exp_row = ~exp_row;
      check("idle_row", 32'(row_n), 32'(exp_row));
    end
    check("idle_keypad", 32'(keypad), 32'h0);
    check("idle_strobes", 32'(strobes - s0), 32'd0);

    // Hold 5: stable at frame 3 end (edge 48), output at edge 49.
    pressed = 12'b0000_0001_0000;
    do_reset();
    s0 = strobes;
    cyc(48);
    check("d5_early", 32'(keypad), 32'h0);
    cyc(1);
    check("d5_keypad", 32'(keypad), 32'h020);
    check("d5_strobe", 32'(key_strobe), 32'h1);
    cyc(1);
    check("d5_strobe_off", 32'(key_strobe), 32'h0);
    cyc(100);
    check("d5_held", 32'(keypad), 32'h020);
    check("d5_one_strobe", 32'(strobes - s0), 32'd1);

    // Bouncing 7: frames see 7,7,NONE,7,7,7 -> output after edge 97.
    pressed = '0;
    do_reset();
    s0 = strobes;
    cyc(5);  pressed[6] = 1'b1;
    cyc(10); pressed[6] = 1'b0;
    cyc(10); pressed[6] = 1'b1;
    cyc(10); pressed[6] = 1'b0;
    cyc(10); pressed[6] = 1'b1;
    cyc(7);
    check("d7_bounce", 32'(keypad), 32'h0);
    cyc(44);
    check("d7_pre", 32'(keypad), 32'h0);
    cyc(1);
    check("d7_keypad", 32'(keypad), 32'h080);
    check("d7_strobe", 32'(key_strobe), 32'h1);
    cyc(50);
    check("d7_one_strobe", 32'(strobes - s0), 32'd1);

    // Two keys together never resolve to a digit.
    pressed = 12'b0000_1000_0010;
    do_reset();
    s0 = strobes;
    cyc(100);
    check("multi_keypad", 32'(keypad), 32'h0);
    check("multi_strobes", 32'(strobes - s0), 32'd0);

    // 3 stable, then 9 added: NONE frames 4..6 clear the output at edge 97.
    pressed = 12'b0000_0000_0100;
    do_reset();
    s0 = strobes;
    cyc(49);
    check("d3_keypad", 32'(keypad), 32'h008);
    check("d3_strobe", 32'(key_strobe), 32'h1);
    cyc(1);
    pressed[8] = 1'b1;
    cyc(46);
    check("d3_9_pre", 32'(keypad), 32'h008);
    cyc(1);
    check("d3_9_clear", 32'(keypad), 32'h0);
    check("d3_9_nostrobe", 32'(key_strobe), 32'h0);
    cyc(20);
    check("d3_9_strobes", 32'(strobes - s0), 32'd1);

    // '*' and '#' are not digits.
    pressed = 12'b0010_0000_0000;
    do_reset();
    s0 = strobes;
    cyc(100);
    check("star_keypad", 32'(keypad), 32'h0);
    check("star_strobes", 32'(strobes - s0), 32'd0);
    pressed = 12'b1000_0000_0000;
    do_reset();
    s0 = strobes;
    cyc(100);
    check("hash_keypad", 32'(keypad), 32'h0);
    check("hash_strobes", 32'(strobes - s0), 32'd0);

    // Digit 0 lives on row 3, column 1.
    pressed = 12'b0100_0000_0000;
    do_reset();
    s0 = strobes;
    cyc(49);
    check("d0_keypad", 32'(keypad), 32'h001);
    check("d0_strobe", 32'(key_strobe), 32'h1);
    cyc(20);
    check("d0_strobes", 32'(strobes - s0), 32'd1);

    // 4 stable, one-cycle reset mid row 2, then re-acquire with a new strobe.
    pressed = 12'b0000_0000_1000;
    do_reset();
    cyc(49);
    check("d4_keypad", 32'(keypad), 32'h010);
    cyc(8);
    check("d4_row2", 32'(row_n), 32'(4'b1011));
    resetn = 1'b0;
    cyc(1);
    check("d4_rst_keypad", 32'(keypad), 32'h0);
    check("d4_rst_row", 32'(row_n), 32'(4'b1110));
    check("d4_rst_strobe", 32'(key_strobe), 32'h0);
    resetn = 1'b1;
    s0 = strobes;
    cyc(48);
    check("d4_re_pre", 32'(keypad), 32'h0);
    cyc(1);
    check("d4_re_keypad", 32'(keypad), 32'h010);
    check("d4_re_strobe", 32'(key_strobe), 32'h1);
    cyc(10);
    check("d4_re_strobes", 32'(strobes - s0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
